// File: rtl/unlock_arbiter.sv
// unlock_arbiter: fixed-priority door-unlock arbiter with availability gating
// and failed-PIN lockout, driving the lock actuator for a fixed hold time.
//
// Ports:
//   FPGA_CLK1_50   system clock (50 MHz)
//   reset_n        synchronous active-low reset
//   available      pulse, set room_available
//   unavailable    pulse, clear room_available (wins over available)
//   exit_req       exit button request, held until acked
//   remote_req     booking host request, held until acked
//   kp_req         keypad request, held until acked
//   kp_pin_ok      PIN verdict, valid while kp_req=1
//   ack[2:0]       one-hot one-cycle ack: [0] exit, [1] remote, [2] keypad
//   ack_ok         1 = granted (unlock started), 0 = denied
//   lock_output    actuator drive, 1 = unlocked
//   room_available registered availability flag
//   lockout        keypad lockout active
//   fail_cnt[2:0]  consecutive wrong PINs
module unlock_arbiter #(
    parameter int unsigned UNLOCK_CYCLES  = 150_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset_n,
    input  logic       available,
    input  logic       unavailable,
    input  logic       exit_req,
    input  logic       remote_req,
    input  logic       kp_req,
    input  logic       kp_pin_ok,
    output logic [2:0] ack,
    output logic       ack_ok,
    output logic       lock_output,
    output logic       room_available,
    output logic       lockout,
    output logic [2:0] fail_cnt
);

    localparam logic [27:0] UNLOCK_LAST = 28'(UNLOCK_CYCLES - 1);
    localparam logic [30:0] LOCK_LAST   = 31'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]  MAX_F       = 3'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UNLOCK  = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] ucnt_q, ucnt_d;
    logic [30:0] lcnt_q, lcnt_d;
    logic [2:0]  ack_d;
    logic        ack_ok_d;
    logic        avail_d;
    logic        lockout_d;
    logic [2:0]  fail_d;
    logic        eval;

    assign lock_output = (state_q == UNLOCK);

    // No decision while unlocking, and none in the cycle that shows an ack,
    // so the requester has time to drop its request.
    assign eval = (state_q != UNLOCK) && (ack == 3'b000);

    always_comb begin
        state_d   = state_q;
        ucnt_d    = ucnt_q;
        lcnt_d    = lcnt_q;
        ack_d     = 3'b000;
        ack_ok_d  = 1'b0;
        lockout_d = lockout;
        fail_d    = fail_cnt;

        if (unavailable) begin
            avail_d = 1'b0;
        end else if (available) begin
            avail_d = 1'b1;
        end else begin
            avail_d = room_available;
        end

        // Timers. The lockout timer only advances in LOCKOUT, so an exit
        // unlock taken during lockout freezes the remaining time.
        unique case (state_q)
            UNLOCK: begin
                if (ucnt_q == UNLOCK_LAST) begin
                    state_d = lockout ? LOCKOUT : IDLE;
                end else begin
                    ucnt_d = ucnt_q + 28'd1;
                end
            end
            LOCKOUT: begin
                if (lcnt_q == LOCK_LAST) begin
                    state_d   = IDLE;
                    lockout_d = 1'b0;
                    fail_d    = 3'd0;
                end else begin
                    lcnt_d = lcnt_q + 31'd1;
                end
            end
            IDLE: begin
            end
            default: state_d = IDLE;
        endcase

        // Decisions override the timer results of the same cycle.
        if (eval) begin
            if (exit_req) begin
                ack_d    = 3'b001;
                ack_ok_d = 1'b1;
                state_d  = UNLOCK;
                ucnt_d   = 28'd0;
            end else if (remote_req) begin
                ack_d = 3'b010;
                if (room_available) begin
                    ack_ok_d  = 1'b1;
                    state_d   = UNLOCK;
                    ucnt_d    = 28'd0;
                    fail_d    = 3'd0;
                    lockout_d = 1'b0;
                end
            end else if (kp_req) begin
                ack_d = 3'b100;
                if (state_q == LOCKOUT) begin
                    ack_ok_d = 1'b0;
                end else if (kp_pin_ok) begin
                    if (room_available) begin
                        ack_ok_d = 1'b1;
                        state_d  = UNLOCK;
                        ucnt_d   = 28'd0;
                        fail_d   = 3'd0;
                    end
                end else begin
                    if (fail_cnt < MAX_F) begin
                        fail_d = fail_cnt + 3'd1;
                    end
                    if ((fail_cnt + 3'd1) == MAX_F) begin
                        state_d   = LOCKOUT;
                        lockout_d = 1'b1;
                        lcnt_d    = 31'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ucnt_q         <= 28'd0;
            lcnt_q         <= 31'd0;
            ack            <= 3'b000;
            ack_ok         <= 1'b0;
            room_available <= 1'b0;
            lockout        <= 1'b0;
            fail_cnt       <= 3'd0;
        end else begin
            state_q        <= state_d;
            ucnt_q         <= ucnt_d;
            lcnt_q         <= lcnt_d;
            ack            <= ack_d;
            ack_ok         <= ack_ok_d;
            room_available <= avail_d;
            lockout        <= lockout_d;
            fail_cnt       <= fail_d;
        end
    end

endmodule

// File: tb/tb_unlock_arbiter.sv
// tb_unlock_arbiter: directed test-plan steps followed by random requests,
// every cycle compared against a time-remaining model of the arbiter.
module tb_unlock_arbiter;

    localparam int U = 10;
    localparam int L = 20;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       available = 1'b0;
    logic       unavailable = 1'b0;
    logic       exit_req = 1'b0;
    logic       remote_req = 1'b0;
    logic       kp_req = 1'b0;
    logic       kp_pin_ok = 1'b0;
    logic [2:0] ack;
    logic       ack_ok;
    logic       lock_output;
    logic       room_available;
    logic       lockout;
    logic [2:0] fail_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Model: remaining unlock time, remaining lockout time, fail count.
    logic [2:0] m_ack = 3'b000;
    bit         m_ok = 1'b0;
    bit         m_avail = 1'b0;
    int         m_fails = 0;
    int         m_unl = 0;
    int         m_lk = 0;

    unlock_arbiter #(
        .UNLOCK_CYCLES (U),
        .LOCKOUT_CYCLES(L),
        .MAX_FAILS     (M)
    ) dut (
        .FPGA_CLK1_50  (clk),
        .reset_n       (reset_n),
        .available     (available),
        .unavailable   (unavailable),
        .exit_req      (exit_req),
        .remote_req    (remote_req),
        .kp_req        (kp_req),
        .kp_pin_ok     (kp_pin_ok),
        .ack           (ack),
        .ack_ok        (ack_ok),
        .lock_output   (lock_output),
        .room_available(room_available),
        .lockout       (lockout),
        .fail_cnt      (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit busy, was_ack, in_lk, ov;
        int of;
        if (!reset_n) begin
            m_ack = 3'b000; m_ok = 0; m_avail = 0;
            m_fails = 0; m_unl = 0; m_lk = 0;
            return;
        end
        busy    = (m_unl > 0);
        was_ack = (m_ack != 3'b000);
        in_lk   = !busy && (m_lk > 0);
        ov      = m_avail;
        of      = m_fails;
        m_ack   = 3'b000;
        m_ok    = 0;
        if (busy) begin
            m_unl--;
        end else if (m_lk > 0) begin
            m_lk--;
            if (m_lk == 0) m_fails = 0;
        end
        if (!busy && !was_ack) begin
            if (exit_req) begin
                m_ack = 3'b001; m_ok = 1; m_unl = U;
            end else if (remote_req) begin
                m_ack = 3'b010;
                if (ov) begin
                    m_ok = 1; m_unl = U; m_fails = 0; m_lk = 0;
                end
            end else if (kp_req) begin
                m_ack = 3'b100;
                if (!in_lk) begin
                    if (kp_pin_ok) begin
                        if (ov) begin
                            m_ok = 1; m_unl = U; m_fails = 0;
                        end
                    end else begin
                        m_fails = (of < M) ? of + 1 : M;
                        if (m_fails == M) m_lk = L;
                    end
                end
            end
        end
        m_avail = unavailable ? 1'b0 : (available ? 1'b1 : ov);
    endtask

    // One clock: model updates on the edge, DUT compared mid-cycle, then
    // requesters drop whatever was just acked.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("ack", ack, m_ack);
        chk("ack_ok", ack_ok, m_ok);
        chk("lock_output", lock_output, m_unl > 0);
        chk("room_available", room_available, m_avail);
        chk("lockout", lockout, m_lk > 0);
        chk("fail_cnt", fail_cnt, m_fails);
        if (ack[0]) exit_req = 1'b0;
        if (ack[1]) remote_req = 1'b0;
        if (ack[2]) kp_req = 1'b0;
    endtask

    task automatic wait_ack(output logic [2:0] a, output logic ok);
        int n = 0;
        do begin
            tick();
            n++;
        end while (ack == 3'b000 && n < 40);
        chk("ack_seen", ack != 3'b000, 1);
        a  = ack;
        ok = ack_ok;
    endtask

    task automatic hold(output int n);
        n = lock_output ? 1 : 0;
        for (int i = 0; i < 50 && lock_output; i++) begin
            tick();
            if (lock_output) n++;
        end
    endtask

    initial begin
        logic [2:0] a;
        logic       ok;
        int         n;
        int         c0;

        // Reset and availability register
        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_lock", lock_output, 0);
        chk("rst_lockout", lockout, 0);
        reset_n = 1'b1;
        available = 1'b1;
        tick();
        available = 1'b0;
        chk("avail_set", room_available, 1);
        available = 1'b1;
        unavailable = 1'b1;
        tick();
        available = 1'b0;
        unavailable = 1'b0;
        chk("avail_both", room_available, 0);
        available = 1'b1;
        tick();
        available = 1'b0;

        // Good PIN with room available
        kp_req = 1'b1;
        kp_pin_ok = 1'b1;
        wait_ack(a, ok);
        chk("kp_ack", a, 3'b100);
        chk("kp_ok", ok, 1);
        chk("kp_lock_rise", lock_output, 1);
        hold(n);
        chk("kp_hold", n, U);
        chk("kp_fail", fail_cnt, 0);

        // Room unavailable: remote denied, exit granted
        unavailable = 1'b1;
        tick();
        unavailable = 1'b0;
        remote_req = 1'b1;
        wait_ack(a, ok);
        chk("rem_deny_ack", a, 3'b010);
        chk("rem_deny_ok", ok, 0);
        chk("rem_deny_lock", lock_output, 0);
        exit_req = 1'b1;
        wait_ack(a, ok);
        chk("exit_ack", a, 3'b001);
        chk("exit_ok", ok, 1);
        hold(n);
        chk("exit_hold", n, U);

        // Three wrong PINs, lockout, expiry
        available = 1'b1;
        tick();
        available = 1'b0;
        c0 = 0;
        for (int i = 1; i <= M; i++) begin
            kp_req = 1'b1;
            kp_pin_ok = 1'b0;
            wait_ack(a, ok);
            chk("bad_ok", ok, 0);
            chk("bad_fail", fail_cnt, i);
            chk("bad_lockout", lockout, i == M);
            c0 = cyc;
        end
        kp_req = 1'b1;
        kp_pin_ok = 1'b1;
        wait_ack(a, ok);
        chk("lk_kp_ok", ok, 0);
        chk("lk_kp_fail", fail_cnt, M);
        n = 0;
        while (lockout && n < 60) begin
            tick();
            n++;
        end
        chk("lk_len", cyc - c0, L);
        chk("lk_fail_clr", fail_cnt, 0);

        // Remote grant aborts lockout
        for (int i = 1; i <= M; i++) begin
            kp_req = 1'b1;
            kp_pin_ok = 1'b0;
            wait_ack(a, ok);
        end
        chk("lk2_on", lockout, 1);
        remote_req = 1'b1;
        wait_ack(a, ok);
        chk("rem_lk_ok", ok, 1);
        chk("rem_lk_clr", lockout, 0);
        chk("rem_lk_fail", fail_cnt, 0);
        hold(n);
        chk("rem_lk_hold", n, U);
        tick();
        chk("rem_lk_idle", lockout, 0);

        // Simultaneous requests: priority order and 1-cycle gaps
        exit_req = 1'b1;
        remote_req = 1'b1;
        kp_req = 1'b1;
        kp_pin_ok = 1'b1;
        wait_ack(a, ok);
        chk("pri_exit", a, 3'b001);
        c0 = cyc;
        wait_ack(a, ok);
        chk("pri_remote", a, 3'b010);
        chk("pri_remote_ok", ok, 1);
        chk("pri_gap1", cyc - c0, U + 1);
        c0 = cyc;
        wait_ack(a, ok);
        chk("pri_kp", a, 3'b100);
        chk("pri_kp_ok", ok, 1);
        chk("pri_gap2", cyc - c0, U + 1);

        // Reset mid-unlock; request held through reset is not acked early
        repeat (3) tick();
        exit_req = 1'b1;
        reset_n = 1'b0;
        tick();
        chk("rst_mid_lock", lock_output, 0);
        tick();
        chk("rst_mid_ack", ack, 0);
        reset_n = 1'b1;
        wait_ack(a, ok);
        chk("rst_exit_ack", a, 3'b001);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            available = ($urandom_range(0, 14) == 0);
            unavailable = ($urandom_range(0, 24) == 0);
            reset_n = ($urandom_range(0, 599) != 0);
            if (!exit_req && $urandom_range(0, 29) == 0) exit_req = 1'b1;
            if (!remote_req && $urandom_range(0, 11) == 0) remote_req = 1'b1;
            if (!kp_req && $urandom_range(0, 5) == 0) begin
                kp_req = 1'b1;
                kp_pin_ok = $urandom_range(0, 1) == 1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
